// File: rtl/eth_tx_arbiter.sv
// Two-source arbiter for the MII transmit byte path: grants one frame source at a time,
// forwards its bytes gap-free, enforces the inter-frame gap and turns underruns and
// over-length frames into tx_er aborts. Define ETH_TX_ARB_RR_EN for round-robin arbitration.
`timescale 1ns/1ps

module eth_tx_arbiter #(
    parameter int IFG_BYTES = 12,
    parameter int MAX_LEN   = 1526,
    parameter int START_TO  = 64,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    output logic [1:0]        gnt,
    input  logic [DATA_W-1:0] s0_data,
    input  logic              s0_valid,
    input  logic              s0_last,
    output logic              s0_ready,
    input  logic [DATA_W-1:0] s1_data,
    input  logic              s1_valid,
    input  logic              s1_last,
    output logic              s1_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_en,
    output logic              tx_er,
    output logic              busy,
    output logic [15:0]       underrun_cnt
);

    localparam int TMR_W = $clog2(MAX_LEN + START_TO + IFG_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        START,
        PASS,
        DRAIN,
        GAP
    } state_t;

    state_t             state, state_nxt;
    logic               sel, sel_nxt;
    logic               win;
    logic [10:0]        len, len_nxt;
    logic [TMR_W-1:0]   tmr, tmr_nxt;
    logic               run_nxt;
    logic               uc_inc;

    logic [DATA_W-1:0]  byte_p0;
    logic               vld_p0;
    logic               last_p0;
    logic               rdy_p0;
    logic               acc_p0;

    logic [DATA_W-1:0]  data_p1;
    logic               vld_p1;
    logic               er_p1;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

`ifdef ETH_TX_ARB_RR_EN
    // prio names the source that wins a tie; it points away from the last grant
    logic prio;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (state_nxt == GAP && state != GAP) begin
            prio <= ~sel;
        end
    end

    always_comb begin
        win = (&req) ? prio : req[1];
    end
`else
    always_comb begin
        win = ~req[0];
    end
`endif

    // stage p0: granted source's byte and handshake
    always_comb begin
        byte_p0 = sel ? s1_data  : s0_data;
        vld_p0  = sel ? s1_valid : s0_valid;
        last_p0 = sel ? s1_last  : s0_last;
        rdy_p0  = sel ? s1_ready : s0_ready;
        acc_p0  = vld_p0 & rdy_p0;
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        len_nxt   = len;
        tmr_nxt   = tmr;
        data_p1   = '0;
        vld_p1    = 1'b0;
        er_p1     = 1'b0;
        uc_inc    = 1'b0;

        case (state)
            IDLE: begin
                if (|req) begin
                    sel_nxt   = win;
                    state_nxt = START;
                    len_nxt   = '0;
                    tmr_nxt   = '0;
                end
            end

            START: begin
                if (acc_p0) begin
                    data_p1 = byte_p0;
                    vld_p1  = 1'b1;
                    len_nxt = 11'd1;
                    tmr_nxt = '0;
                    state_nxt = last_p0 ? GAP : PASS;
                end else if (tmr == TMR_W'(START_TO - 1)) begin
                    state_nxt = GAP;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end

            PASS: begin
                vld_p1  = 1'b1;
                tmr_nxt = '0;
                if (acc_p0) begin
                    data_p1 = byte_p0;
                    len_nxt = len + 11'd1;
                    if (last_p0) begin
                        state_nxt = GAP;
                    end else if (len == 11'(MAX_LEN - 1)) begin
                        // a full-length byte without last can only be followed by an over-length one
                        er_p1     = 1'b1;
                        uc_inc    = 1'b1;
                        state_nxt = DRAIN;
                    end
                end else begin
                    er_p1     = 1'b1;
                    uc_inc    = 1'b1;
                    state_nxt = DRAIN;
                end
            end

            DRAIN: begin
                // bounded by cycles, not bytes, so a silent source still releases the link
                if ((acc_p0 && last_p0) || tmr == TMR_W'(MAX_LEN - 1)) begin
                    state_nxt = GAP;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end

            GAP: begin
                if (tmr == TMR_W'(IFG_BYTES - 1)) begin
                    state_nxt = IDLE;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        run_nxt = (state_nxt == START) || (state_nxt == PASS) || (state_nxt == DRAIN);
    end

    // stage p1: registered control and output byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sel          <= 1'b0;
            len          <= '0;
            tmr          <= '0;
            gnt          <= 2'b00;
            s0_ready     <= 1'b0;
            s1_ready     <= 1'b0;
            tx_data      <= '0;
            tx_en        <= 1'b0;
            tx_er        <= 1'b0;
            busy         <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            state    <= state_nxt;
            sel      <= sel_nxt;
            len      <= len_nxt;
            tmr      <= tmr_nxt;
            gnt      <= run_nxt ? (sel_nxt ? 2'b10 : 2'b01) : 2'b00;
            s0_ready <= run_nxt & ~sel_nxt;
            s1_ready <= run_nxt & sel_nxt;
            tx_data  <= data_p1;
            tx_en    <= vld_p1;
            tx_er    <= er_p1;
            busy     <= (state_nxt != IDLE);
            if (uc_inc) begin
                underrun_cnt <= sat_inc(underrun_cnt);
            end
        end
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: frame table with a byte scoreboard plus
// hand-written start-timeout, reset-mid-frame and back-to-back arbitration sequences.
`timescale 1ns/1ps

module tb_eth_tx_arbiter;

    localparam int IFG_BYTES = 12;
    localparam int MAX_LEN   = 1526;
    localparam int START_TO  = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [7:0]  s0_data, s1_data;
    logic        s0_valid, s1_valid;
    logic        s0_last, s1_last;
    logic        s0_ready, s1_ready;
    logic [7:0]  tx_data;
    logic        tx_en, tx_er, busy;
    logic [15:0] underrun_cnt;

    eth_tx_arbiter #(
        .IFG_BYTES(IFG_BYTES),
        .MAX_LEN  (MAX_LEN),
        .START_TO (START_TO),
        .DATA_W   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .gnt         (gnt),
        .s0_data     (s0_data),
        .s0_valid    (s0_valid),
        .s0_last     (s0_last),
        .s0_ready    (s0_ready),
        .s1_data     (s1_data),
        .s1_valid    (s1_valid),
        .s1_last     (s1_last),
        .s1_ready    (s1_ready),
        .tx_data     (tx_data),
        .tx_en       (tx_en),
        .tx_er       (tx_er),
        .busy        (busy),
        .underrun_cnt(underrun_cnt)
    );

    always #4 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       er;
        logic       eop;
    } exp_t;

    typedef struct {
        int         src;
        int         nbytes;
        bit         has_last;
        int         drop_at;
        logic [1:0] exp_gnt;
        int         exp_tx;
        int         exp_uc_delta;
    } vec_t;

    exp_t sbq[$];
    int   gaps[$];
    int   checks = 0;
    int   errors = 0;
    int   tx_cycles = 0;
    int   idle_run = 0;
    bit   seen_pulse = 0;
    bit   prev_en = 0;
    bit   prev_eop = 0;
    int   exp_uc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [7:0] byte_of(input int src, input int k);
        if (k <= 7) return 8'h55;
        if (k == 8) return 8'hD5;
        return 8'((k - 9) + src * 8'h40);
    endfunction

    task automatic drive(input int src, input logic v, input logic [7:0] d, input logic l);
        s0_valid = (src == 0) && v;
        s0_data  = (src == 0) ? d : 8'h00;
        s0_last  = (src == 0) && l;
        s1_valid = (src == 1) && v;
        s1_data  = (src == 1) ? d : 8'h00;
        s1_last  = (src == 1) && l;
    endtask

    // Output monitor: pops the scoreboard on every tx_en byte and tracks the idle run between pulses.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_en    = 0;
            idle_run   = 0;
            seen_pulse = 0;
        end else begin
            if (tx_en) begin
                if (!prev_en && seen_pulse) begin
                    gaps.push_back(idle_run);
                    check("ifg_min", idle_run >= IFG_BYTES, 1);
                end
                tx_cycles++;
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got byte %0h er %0b, none expected at %0t", tx_data, tx_er, $time);
                end else begin
                    e = sbq.pop_front();
                    check("tx_data", tx_data, e.data);
                    check("tx_er", tx_er, e.er);
                    prev_eop = e.eop;
                end
                idle_run   = 0;
                seen_pulse = 1;
            end else begin
                if (prev_en) check("tx_en_hold_to_end", prev_eop, 1);
                check("tx_er_idle", tx_er, 0);
                idle_run++;
            end
            prev_en = tx_en;
        end
    end

    // Waits for a grant, then plays the granted source's frame until the DUT returns to IDLE.
    task automatic run_frame(input int nbytes, input bit has_last, input int drop_at,
                             input bit drop_req, output logic [1:0] got, output int lat);
        int   src, k;
        bit   fwd, started, dropped, done_ok;
        logic v, l, rdy, other_rdy;
        logic [7:0] d;
        tx_cycles = 0;
        got = 2'b00;
        lat = 0;
        done_ok = 0;
        while (gnt == 2'b00 && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        if (gnt == 2'b00) begin
            checks++;
            errors++;
            $display("FAIL grant_wait: got gnt 0 after %0d cycles, required nonzero", lat);
            return;
        end
        got = gnt;
        if (drop_req) req = 2'b00;
        src = got[1] ? 1 : 0;
        k = 1;
        fwd = 1;
        started = 0;
        dropped = 0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (k > nbytes) begin
                v = 0; d = 8'h00; l = 0;
            end else if (drop_at != 0 && k == drop_at + 1 && !dropped) begin
                v = 0; d = 8'h00; l = 0; dropped = 1;
            end else begin
                v = 1; d = byte_of(src, k); l = has_last && (k == nbytes);
            end
            drive(src, v, d, l);
            rdy       = src ? s1_ready : s0_ready;
            other_rdy = src ? s0_ready : s1_ready;
            check("ungranted_ready", other_rdy, 0);
            if (v && rdy) begin
                if (fwd) begin
                    if (k == MAX_LEN && !l) begin
                        sbq.push_back('{data: d, er: 1'b1, eop: 1'b1});
                        fwd = 0;
                    end else begin
                        sbq.push_back('{data: d, er: 1'b0, eop: l});
                    end
                end
                started = 1;
                k++;
            end else if (!v && rdy && fwd && started) begin
                sbq.push_back('{data: 8'h00, er: 1'b1, eop: 1'b1});
                fwd = 0;
            end
            @(posedge clk); #1;
            if (!busy) begin
                done_ok = 1;
                break;
            end
        end
        drive(src, 0, 8'h00, 0);
        if (!done_ok) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: busy still %0b, required 0", busy);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[7];
        logic [1:0] got;
        logic [1:0] arb_exp[3];
        int         lat, n;

        vecs[0] = '{0,   60, 1,  0, 2'b01,      60, 0};
        vecs[1] = '{1,   64, 1, 20, 2'b10,      21, 1};
        vecs[2] = '{0,   64, 1,  0, 2'b01,      64, 0};
        vecs[3] = '{1,    1, 1,  0, 2'b10,       1, 0};
        vecs[4] = '{0, 1530, 0,  0, 2'b01, MAX_LEN, 1};
        vecs[5] = '{0, MAX_LEN, 1, 0, 2'b01, MAX_LEN, 0};
        vecs[6] = '{1,   10, 1,  1, 2'b10,       2, 1};

`ifdef ETH_TX_ARB_RR_EN
        arb_exp = '{2'b01, 2'b10, 2'b01};
`else
        arb_exp = '{2'b01, 2'b01, 2'b01};
`endif

        rst = 1'b1;
        req = 2'b00;
        drive(0, 0, 8'h00, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_s0_ready", s0_ready, 0);
        check("rst_s1_ready", s1_ready, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_en", tx_en, 0);
        check("rst_tx_er", tx_er, 0);
        check("rst_busy", busy, 0);
        check("rst_ucnt", underrun_cnt, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            req = (vecs[i].src == 0) ? 2'b01 : 2'b10;
            run_frame(vecs[i].nbytes, vecs[i].has_last, vecs[i].drop_at, 1, got, lat);
            exp_uc += vecs[i].exp_uc_delta;
            check($sformatf("v%0d_gnt", i), got, vecs[i].exp_gnt);
            check($sformatf("v%0d_gnt_latency", i), lat, 1);
            check($sformatf("v%0d_tx_count", i), tx_cycles, vecs[i].exp_tx);
            check($sformatf("v%0d_ucnt", i), underrun_cnt, exp_uc);
            check($sformatf("v%0d_sb_left", i), sbq.size(), 0);
        end

        // start timeout: granted source never presents a byte
        tx_cycles = 0;
        req = 2'b01;
        n = 0;
        for (int i = 0; i < 8 && gnt == 2'b00; i++) begin
            @(posedge clk); #1;
        end
        req = 2'b00;
        while (gnt != 2'b00 && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        check("to_gnt_cycles", n, START_TO);
        for (int i = 0; i < 40 && busy; i++) begin
            @(posedge clk); #1;
        end
        check("to_busy_after_gap", busy, 0);
        check("to_tx_count", tx_cycles, 0);
        check("to_ucnt", underrun_cnt, exp_uc);

        // reset at byte 30 of a 100-byte frame
        req = 2'b01;
        for (int i = 0; i < 8 && gnt == 2'b00; i++) begin
            @(posedge clk); #1;
        end
        req = 2'b00;
        check("mid_gnt", gnt, 2'b01);
        begin
            int k = 1;
            for (int cyc = 0; cyc < 100 && k <= 30; cyc++) begin
                drive(0, 1, byte_of(0, k), 0);
                if (s0_ready) begin
                    sbq.push_back('{data: byte_of(0, k), er: 1'b0, eop: 1'b0});
                    k++;
                end
                @(posedge clk); #1;
            end
            check("mid_bytes_sent", k, 31);
        end
        check("mid_ucnt_before", underrun_cnt, exp_uc);
        check("mid_tx_en_before", tx_en, 1);
        rst = 1'b1;
        #1;
        check("arst_tx_en", tx_en, 0);
        check("arst_gnt", gnt, 0);
        check("arst_s0_ready", s0_ready, 0);
        check("arst_tx_data", tx_data, 0);
        check("arst_busy", busy, 0);
        check("arst_ucnt", underrun_cnt, 0);
        check("arst_sb_pending", sbq.size(), 1);
        sbq.delete();
        exp_uc = 0;
        drive(0, 0, 8'h00, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req = 2'b10;
        run_frame(40, 1, 0, 1, got, lat);
        check("post_rst_gnt", got, 2'b10);
        check("post_rst_latency", lat, 1);
        check("post_rst_tx_count", tx_cycles, 40);
        check("post_rst_ucnt", underrun_cnt, 0);

        // three back-to-back frames with both requests held
        req = 2'b11;
        for (int f = 0; f < 3; f++) begin
            run_frame(64, 1, 0, f == 2, got, lat);
            check($sformatf("arb%0d_gnt", f), got, arb_exp[f]);
            check($sformatf("arb%0d_tx_count", f), tx_cycles, 64);
            if (f == 0) gaps.delete();
        end
        req = 2'b00;
        check("arb_gap_count", gaps.size(), 2);
        while (gaps.size() > 0) begin
            check("arb_gap_exact", gaps.pop_front(), IFG_BYTES + 1);
        end
        check("arb_sb_left", sbq.size(), 0);
        check("arb_ucnt", underrun_cnt, 0);

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
